// File: rtl/avmm_wr_outstanding_limiter.sv
// -----------------------------------------------------------------------------
// avmm_wr_outstanding_limiter
//
// Purpose:
//   Write-path credit limiter that sits in front of the per-word write-ack
//   generator. It tracks how many write words have been issued downstream but
//   not yet acknowledged. A new burst is held off with waitrequest on its first
//   beat if admitting the whole burst would push that count above
//   MAX_OUTSTANDING. The whole burst is reserved on the first beat, so the
//   remaining beats of an admitted burst are never blocked. Per-word acks from
//   downstream return the credit and are echoed to the kernel one cycle later.
//
// Optional feature (macro AVMM_WR_LIMIT_STATS_EN):
//   When defined, a saturating credit-stall counter and a high-water mark of
//   the outstanding count are kept. When undefined, both ports read 0 and no
//   statistics registers exist.
//
// Ports:
//   kernel_avmm_clk / kernel_avmm_reset  clock, synchronous active-high reset
//   s_avmm_*                             kernel-side write command, waitreq, ack
//   m_avmm_*                             downstream write command (pass-through),
//                                        waitreq and per-word ack
//   outstanding                          current outstanding word count
//   err_ack_underflow                    sticky: ack seen with nothing outstanding
//   err_zero_burst                       sticky: first beat with burstcnt==0
//   stall_cycles / peak_outstanding      statistics (0 unless stats enabled)
// -----------------------------------------------------------------------------
module avmm_wr_outstanding_limiter #(
  parameter int AVMM_ADDR_WIDTH     = 32,
  parameter int AVMM_BURSTCNT_WIDTH = 5,
  parameter int AVMM_DATA_WIDTH     = 512,
  parameter int MAX_OUTSTANDING     = 512,
  localparam int CNT_W              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                           kernel_avmm_clk,
  input  logic                           kernel_avmm_reset,
  input  logic                           s_avmm_wr,
  input  logic [AVMM_BURSTCNT_WIDTH-1:0] s_avmm_burstcnt,
  input  logic [AVMM_ADDR_WIDTH-1:0]     s_avmm_address,
  input  logic [AVMM_DATA_WIDTH-1:0]     s_avmm_writedata,
  input  logic [AVMM_DATA_WIDTH/8-1:0]   s_avmm_byteenable,
  output logic                           s_avmm_waitreq,
  output logic                           s_avmm_wr_ack,
  output logic                           m_avmm_wr,
  output logic [AVMM_BURSTCNT_WIDTH-1:0] m_avmm_burstcnt,
  output logic [AVMM_ADDR_WIDTH-1:0]     m_avmm_address,
  output logic [AVMM_DATA_WIDTH-1:0]     m_avmm_writedata,
  output logic [AVMM_DATA_WIDTH/8-1:0]   m_avmm_byteenable,
  input  logic                           m_avmm_waitreq,
  input  logic                           m_avmm_wr_ack,
  output logic [CNT_W-1:0]               outstanding,
  output logic                           err_ack_underflow,
  output logic                           err_zero_burst,
  output logic [31:0]                    stall_cycles,
  output logic [CNT_W-1:0]               peak_outstanding
);

  // A burst larger than the credit pool could never be admitted.
  generate
    if (MAX_OUTSTANDING < (1 << (AVMM_BURSTCNT_WIDTH - 1))) begin : g_bad_cfg
      $error("MAX_OUTSTANDING must be >= maximum burst length");
    end
  endgenerate

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  localparam logic [CNT_W:0] ONE_W = (CNT_W + 1)'(1);

  state_t                         r_state, w_state_next;
  logic [CNT_W-1:0]               r_outstanding, w_outstanding_next;
  logic [AVMM_BURSTCNT_WIDTH-1:0] r_beats_left, w_beats_left_next;
  logic [CNT_W:0]                 w_eff_len, w_sum;
  logic                           w_block, w_accept, w_first, w_ack_dec;
  logic                           r_wr_ack, r_err_ack_underflow, r_err_zero_burst;

  // A zero burstcount is treated as a single word so credit is still taken.
  assign w_eff_len = (s_avmm_burstcnt == '0) ? ONE_W : (CNT_W + 1)'(s_avmm_burstcnt);
  // One extra bit so the admission sum cannot wrap.
  assign w_sum     = {1'b0, r_outstanding} + w_eff_len;
  // Admission is only decided on the first beat; mid-burst beats own their credit.
  assign w_block   = (r_state == S_IDLE) && (w_sum > (CNT_W + 1)'(MAX_OUTSTANDING));

  assign s_avmm_waitreq    = m_avmm_waitreq | w_block | kernel_avmm_reset;
  assign m_avmm_wr         = s_avmm_wr & ~w_block & ~kernel_avmm_reset;
  assign m_avmm_burstcnt   = s_avmm_burstcnt;
  assign m_avmm_address    = s_avmm_address;
  assign m_avmm_writedata  = s_avmm_writedata;
  assign m_avmm_byteenable = s_avmm_byteenable;

  assign w_accept  = s_avmm_wr & ~s_avmm_waitreq;
  assign w_first   = w_accept & (r_state == S_IDLE);
  assign w_ack_dec = m_avmm_wr_ack & (r_outstanding != '0);

  // Uses the pre-update count, so a same-cycle ack nets against the new burst.
  assign w_outstanding_next = CNT_W'({1'b0, r_outstanding}
                                     + (w_first ? w_eff_len : '0)
                                     - (w_ack_dec ? ONE_W : '0));

  always_comb begin
    w_state_next      = r_state;
    w_beats_left_next = r_beats_left;
    case (r_state)
      S_IDLE: begin
        if (w_first && (w_eff_len > ONE_W)) begin
          w_state_next      = S_BURST;
          w_beats_left_next = AVMM_BURSTCNT_WIDTH'(w_eff_len - ONE_W);
        end
      end
      S_BURST: begin
        if (w_accept) begin
          w_beats_left_next = r_beats_left - AVMM_BURSTCNT_WIDTH'(1);
          if (r_beats_left == AVMM_BURSTCNT_WIDTH'(1)) begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge kernel_avmm_clk) begin
    if (kernel_avmm_reset) begin
      r_state             <= S_IDLE;
      r_outstanding       <= '0;
      r_beats_left        <= '0;
      r_wr_ack            <= 1'b0;
      r_err_ack_underflow <= 1'b0;
      r_err_zero_burst    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;
      r_beats_left  <= w_beats_left_next;
      r_wr_ack      <= m_avmm_wr_ack;
      if (m_avmm_wr_ack && (r_outstanding == '0)) begin
        r_err_ack_underflow <= 1'b1;
      end
      if (w_first && (s_avmm_burstcnt == '0)) begin
        r_err_zero_burst <= 1'b1;
      end
    end
  end

  assign s_avmm_wr_ack     = r_wr_ack;
  assign outstanding       = r_outstanding;
  assign err_ack_underflow = r_err_ack_underflow;
  assign err_zero_burst    = r_err_zero_burst;

`ifdef AVMM_WR_LIMIT_STATS_EN
  logic [31:0]      r_stall_cycles;
  logic [CNT_W-1:0] r_peak_outstanding;

  always_ff @(posedge kernel_avmm_clk) begin
    if (kernel_avmm_reset) begin
      r_stall_cycles     <= '0;
      r_peak_outstanding <= '0;
    end else begin
      // Only credit stalls count; downstream waitrequest stalls do not.
      if (s_avmm_wr && w_block && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_outstanding_next > r_peak_outstanding) begin
        r_peak_outstanding <= w_outstanding_next;
      end
    end
  end

  assign stall_cycles     = r_stall_cycles;
  assign peak_outstanding = r_peak_outstanding;
`else
  assign stall_cycles     = '0;
  assign peak_outstanding = '0;
`endif

endmodule

// File: tb/tb_avmm_wr_outstanding_limiter.sv
// -----------------------------------------------------------------------------
// tb_avmm_wr_outstanding_limiter
//
// Directed scoreboard bench. Each driven beat pushes its expected downstream
// image into a queue; each driven ack pushes the cycle its echo must appear.
// A negedge monitor pops and compares whenever the DUT presents a downstream
// beat transfer or a kernel-side ack. State checks are made inline.
// Works with or without AVMM_WR_LIMIT_STATS_EN.
// -----------------------------------------------------------------------------
module tb_avmm_wr_outstanding_limiter;

  localparam int AW    = 16;
  localparam int BW    = 7;
  localparam int DW    = 32;
  localparam int MAXO  = 64;
  localparam int CW    = 7;
  localparam int EW    = BW + AW + DW + DW/8;

  logic            clk;
  logic            srst;
  logic            s_avmm_wr;
  logic [BW-1:0]   s_avmm_burstcnt;
  logic [AW-1:0]   s_avmm_address;
  logic [DW-1:0]   s_avmm_writedata;
  logic [DW/8-1:0] s_avmm_byteenable;
  logic            s_avmm_waitreq;
  logic            s_avmm_wr_ack;
  logic            m_avmm_wr;
  logic [BW-1:0]   m_avmm_burstcnt;
  logic [AW-1:0]   m_avmm_address;
  logic [DW-1:0]   m_avmm_writedata;
  logic [DW/8-1:0] m_avmm_byteenable;
  logic            m_avmm_waitreq;
  logic            m_avmm_wr_ack;
  logic [CW-1:0]   outstanding;
  logic            err_ack_underflow;
  logic            err_zero_burst;
  logic [31:0]     stall_cycles;
  logic [CW-1:0]   peak_outstanding;

  avmm_wr_outstanding_limiter #(
    .AVMM_ADDR_WIDTH    (AW),
    .AVMM_BURSTCNT_WIDTH(BW),
    .AVMM_DATA_WIDTH    (DW),
    .MAX_OUTSTANDING    (MAXO)
  ) dut (
    .kernel_avmm_clk  (clk),
    .kernel_avmm_reset(srst),
    .s_avmm_wr        (s_avmm_wr),
    .s_avmm_burstcnt  (s_avmm_burstcnt),
    .s_avmm_address   (s_avmm_address),
    .s_avmm_writedata (s_avmm_writedata),
    .s_avmm_byteenable(s_avmm_byteenable),
    .s_avmm_waitreq   (s_avmm_waitreq),
    .s_avmm_wr_ack    (s_avmm_wr_ack),
    .m_avmm_wr        (m_avmm_wr),
    .m_avmm_burstcnt  (m_avmm_burstcnt),
    .m_avmm_address   (m_avmm_address),
    .m_avmm_writedata (m_avmm_writedata),
    .m_avmm_byteenable(m_avmm_byteenable),
    .m_avmm_waitreq   (m_avmm_waitreq),
    .m_avmm_wr_ack    (m_avmm_wr_ack),
    .outstanding      (outstanding),
    .err_ack_underflow(err_ack_underflow),
    .err_zero_burst   (err_zero_burst),
    .stall_cycles     (stall_cycles),
    .peak_outstanding (peak_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  logic [EW-1:0] exp_q[$];
  int            ack_q[$];
  logic [AW-1:0] next_addr = 16'h0100;
  int            last_ack_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [EW-1:0] beat_vec(input logic [BW-1:0] bc, input logic [AW-1:0] a);
    return {bc, a, a, ~a, a[3:0]};
  endfunction

  // Monitor: downstream beat transfers and echoed acks.
  always @(negedge clk) begin
    if (m_avmm_wr && !m_avmm_waitreq) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
      else chk($sformatf("beat@%0d", cyc),
               longint'({m_avmm_burstcnt, m_avmm_address, m_avmm_writedata, m_avmm_byteenable}),
               longint'(exp_q.pop_front()));
    end
    if (s_avmm_wr_ack) begin
      if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
      else chk("ack_cycle", cyc, ack_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one beat, wait (bounded) until accepted; returns the accept cycle.
  task automatic send_beat(input logic [BW-1:0] bc, input bit toggle, output int acc_cyc);
    logic [AW-1:0] a;
    a = next_addr;
    next_addr = next_addr + 16'd1;
    exp_q.push_back(beat_vec(bc, a));
    s_avmm_wr         = 1'b1;
    s_avmm_burstcnt   = bc;
    s_avmm_address    = a;
    s_avmm_writedata  = {a, ~a};
    s_avmm_byteenable = a[3:0];
    acc_cyc = -1;
    for (int n = 0; n < 100; n++) begin
      if (toggle) m_avmm_waitreq = ~m_avmm_waitreq;
      @(negedge clk);
      if (!s_avmm_waitreq) begin
        acc_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc_cyc < 0) begin
      chk("beat_accept_timeout", 0, 1);
      void'(exp_q.pop_back());
    end else begin
      @(posedge clk); #1;
    end
    s_avmm_wr = 1'b0;
  endtask

  task automatic ack_n(input int n);
    for (int i = 0; i < n; i++) begin
      m_avmm_wr_ack = 1'b1;
      ack_q.push_back(cyc + 1);
      last_ack_cyc = cyc;
      step();
    end
    m_avmm_wr_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, start;
    srst = 1'b1;
    s_avmm_wr = 1'b1;  // must not leak downstream during reset
    s_avmm_burstcnt = 7'd1;
    s_avmm_address = '0;
    s_avmm_writedata = '0;
    s_avmm_byteenable = '0;
    m_avmm_waitreq = 1'b0;
    m_avmm_wr_ack = 1'b0;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    chk("rst_waitreq", s_avmm_waitreq, 1);
    chk("rst_m_wr", m_avmm_wr, 0);
    chk("rst_outstanding", outstanding, 0);
    step();
    s_avmm_wr = 1'b0;
    srst = 1'b0;
    step();
    chk("rst_err_underflow", err_ack_underflow, 0);
    chk("rst_err_zero", err_zero_burst, 0);
    chk("rst_s_ack", s_avmm_wr_ack, 0);
    chk("rst_stall", stall_cycles, 0);

    // Single-word write, no stall, then one ack
    start = cyc;
    send_beat(7'd1, 1'b0, acc);
    chk("single_latency", acc - start, 0);
    chk("single_outstanding", outstanding, 1);
    ack_n(1);
    chk("single_ack_outstanding", outstanding, 0);

    // Fill exactly to the limit with a 64-word burst
    for (int i = 0; i < 64; i++) send_beat((i == 0) ? 7'd64 : 7'd3, 1'b0, acc);
    chk("full_outstanding", outstanding, 64);

    // A 4-word burst must wait until four acks have retired
    start = cyc;
    fork
      send_beat(7'd4, 1'b0, acc);
      begin
        repeat (3) step();
        ack_n(4);
      end
    join
    chk("blocked_admit_cycle", acc, last_ack_cyc + 1);
    chk("blocked_stall_len", acc - start, 7);
    for (int i = 0; i < 3; i++) send_beat(7'd9, 1'b0, acc);
    chk("refill_outstanding", outstanding, 64);
`ifdef AVMM_WR_LIMIT_STATS_EN
    chk("stall_cycles", stall_cycles, 7);
    chk("peak_64", peak_outstanding, 64);
`else
    chk("stall_cycles_off", stall_cycles, 0);
    chk("peak_off", peak_outstanding, 0);
`endif

    // Burst of 8 with toggling downstream waitreq, ending exactly at the limit.
    // Later beats carry a burstcnt that would block if admission were re-evaluated.
    ack_n(8);
    chk("pre8_outstanding", outstanding, 56);
    for (int i = 0; i < 8; i++) send_beat(7'd8, 1'b1, acc);
    m_avmm_waitreq = 1'b0;
    chk("burst8_outstanding", outstanding, 64);
    // Back in IDLE: a new single-word burst must now be credit-blocked.
    s_avmm_wr = 1'b1;
    s_avmm_burstcnt = 7'd1;
    @(negedge clk);
    chk("idle_after_burst_blocked", s_avmm_waitreq, 1);
    step();
    s_avmm_wr = 1'b0;

    // outstanding=10, 4-word first beat with a same-cycle ack -> 13
    ack_n(54);
    chk("ten_outstanding", outstanding, 10);
    fork
      send_beat(7'd4, 1'b0, acc);
      ack_n(1);
    join
    chk("accept_plus_ack", outstanding, 13);
    for (int i = 0; i < 3; i++) send_beat(7'd2, 1'b0, acc);
    chk("accept_plus_ack_tail", outstanding, 13);
    ack_n(13);
    chk("drained", outstanding, 0);

    // Underflow and zero-length burst
    ack_n(1);
    chk("underflow_err", err_ack_underflow, 1);
    chk("underflow_outstanding", outstanding, 0);
    send_beat(7'd0, 1'b0, acc);
    chk("zero_burst_err", err_zero_burst, 1);
    chk("zero_burst_outstanding", outstanding, 1);
    ack_n(1);

    // Reset mid-burst with beats_left=5
    for (int i = 0; i < 3; i++) send_beat((i == 0) ? 7'd8 : 7'd1, 1'b0, acc);
    chk("midburst_outstanding", outstanding, 8);
    exp_q.delete();
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_err_underflow", err_ack_underflow, 0);
    chk("midrst_err_zero", err_zero_burst, 0);
    chk("midrst_stall", stall_cycles, 0);
    chk("midrst_peak", peak_outstanding, 0);
    ack_n(1);
    chk("post_rst_underflow", err_ack_underflow, 1);
    // IDLE after reset: a 2-word burst reserves 2 on its first beat
    send_beat(7'd2, 1'b0, acc);
    chk("post_rst_first", outstanding, 2);
    send_beat(7'd5, 1'b0, acc);
    chk("post_rst_second", outstanding, 2);
`ifdef AVMM_WR_LIMIT_STATS_EN
    chk("peak_after_rst", peak_outstanding, 2);
`endif
    ack_n(2);
    repeat (3) step();
    chk("final_outstanding", outstanding, 0);
    chk("beat_q_empty", exp_q.size(), 0);
    chk("ack_q_empty", ack_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
